// File: rtl/sd_blk_server.sv
// Four-drive SD block server: round-robin arbitrates 512-byte block reads/writes onto a byte memory.
// Define SD_BLK_SERVER_STATS_EN to enable the rd_blocks/wr_blocks completion counters.
module sd_blk_server #(
    parameter int IMG_LBA_BITS = 11
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [3:0]                sd_rd,
    input  logic [3:0]                sd_wr,
    input  logic [127:0]              sd_lba,
    output logic [3:0]                sd_ack,
    output logic [8:0]                sd_buff_addr,
    output logic [7:0]                sd_buff_dout,
    output logic                      sd_buff_wr,
    input  logic [31:0]               sd_buff_din,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [IMG_LBA_BITS+10:0]  mem_addr,
    output logic [7:0]                mem_wdata,
    input  logic [7:0]                mem_rdata,
    input  logic                      mem_ack,
    output logic                      lba_err,
    output logic [15:0]               rd_blocks,
    output logic [15:0]               wr_blocks
);

    typedef enum logic [2:0] {
        IDLE, ACK, RD_FETCH, RD_PUT, WR_ADDR, WR_WAIT, WR_STORE, DONE
    } state_t;

    state_t      state_q;
    logic [1:0]  drv_q;
    logic [1:0]  rr_q;
    logic        is_wr_q;
    logic [31:0] lba_q;
    logic [8:0]  idx_q;
    logic        wait_q;
    logic [3:0]  armed_q;

    logic [3:0]  eligible;
    logic        found;
    logic [1:0]  pick;
    logic [1:0]  cand;
    logic        oor;
    logic [7:0]  din_sel;

    assign eligible = (sd_rd | sd_wr) & armed_q;
    assign oor      = |lba_q[31:IMG_LBA_BITS];
    assign din_sel  = sd_buff_din[{drv_q, 3'd0} +: 8];

    // First eligible drive at or after the round-robin pointer.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        cand  = rr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_q + 2'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            drv_q        <= 2'd0;
            rr_q         <= 2'd0;
            is_wr_q      <= 1'b0;
            lba_q        <= 32'd0;
            idx_q        <= 9'd0;
            wait_q       <= 1'b0;
            armed_q      <= 4'hF;
            sd_ack       <= 4'd0;
            sd_buff_addr <= 9'd0;
            sd_buff_dout <= 8'd0;
            sd_buff_wr   <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 8'd0;
            lba_err      <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!sd_rd[i] && !sd_wr[i]) armed_q[i] <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        drv_q   <= pick;
                        is_wr_q <= !sd_rd[pick];
                        lba_q   <= sd_lba[{pick, 5'd0} +: 32];
                        rr_q    <= pick + 2'd1;
                        sd_ack  <= 4'b0001 << pick;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    if (oor) lba_err <= 1'b1;
                    idx_q <= 9'd0;
                    if (is_wr_q) begin
                        sd_buff_addr <= 9'd0;
                        state_q      <= WR_ADDR;
                    end else begin
                        mem_req  <= !oor;
                        mem_we   <= 1'b0;
                        mem_addr <= {drv_q, lba_q[IMG_LBA_BITS-1:0], 9'd0};
                        state_q  <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    if (oor || mem_ack) begin
                        mem_req      <= 1'b0;
                        sd_buff_dout <= oor ? 8'd0 : mem_rdata;
                        sd_buff_wr   <= 1'b1;
                        sd_buff_addr <= idx_q;
                        state_q      <= RD_PUT;
                    end
                end
                RD_PUT: begin
                    sd_buff_wr <= 1'b0;
                    if (idx_q == 9'd511) begin
                        state_q <= DONE;
                    end else begin
                        idx_q    <= idx_q + 9'd1;
                        mem_req  <= !oor;
                        mem_addr <= {drv_q, lba_q[IMG_LBA_BITS-1:0], idx_q + 9'd1};
                        state_q  <= RD_FETCH;
                    end
                end
                WR_ADDR: begin
                    wait_q  <= 1'b0;
                    state_q <= WR_WAIT;
                end
                WR_WAIT: begin
                    // Buffer data for sd_buff_addr is valid on the second wait cycle.
                    if (wait_q) begin
                        mem_wdata <= din_sel;
                        mem_we    <= 1'b1;
                        mem_req   <= !oor;
                        mem_addr  <= {drv_q, lba_q[IMG_LBA_BITS-1:0], idx_q};
                        state_q   <= WR_STORE;
                    end else begin
                        wait_q <= 1'b1;
                    end
                end
                WR_STORE: begin
                    if (oor || mem_ack) begin
                        mem_req <= 1'b0;
                        if (idx_q == 9'd511) begin
                            state_q <= DONE;
                        end else begin
                            idx_q        <= idx_q + 9'd1;
                            sd_buff_addr <= idx_q + 9'd1;
                            state_q      <= WR_ADDR;
                        end
                    end
                end
                DONE: begin
                    sd_ack         <= 4'd0;
                    armed_q[drv_q] <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SD_BLK_SERVER_STATS_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_blocks <= 16'd0;
            wr_blocks <= 16'd0;
        end else if (state_q == DONE) begin
            if (is_wr_q) wr_blocks <= wr_blocks + 16'd1;
            else         rd_blocks <= rd_blocks + 16'd1;
        end
    end
`else
    assign rd_blocks = 16'd0;
    assign wr_blocks = 16'd0;
`endif

endmodule

// File: tb/tb_sd_blk_server.sv
// Directed bench for sd_blk_server with a one-cycle-ack memory model and a 2-cycle-latency buffer.
module tb_sd_blk_server;

    logic         CLK;
    logic         RESET_N;
    logic [3:0]   sd_rd;
    logic [3:0]   sd_wr;
    logic [127:0] sd_lba;
    logic [3:0]   sd_ack;
    logic [8:0]   sd_buff_addr;
    logic [7:0]   sd_buff_dout;
    logic         sd_buff_wr;
    logic [31:0]  sd_buff_din;
    logic         mem_req;
    logic         mem_we;
    logic [21:0]  mem_addr;
    logic [7:0]   mem_wdata;
    logic [7:0]   mem_rdata;
    logic         mem_ack;
    logic         lba_err;
    logic [15:0]  rd_blocks;
    logic [15:0]  wr_blocks;

`ifdef SD_BLK_SERVER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    sd_blk_server #(.IMG_LBA_BITS(11)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_lba       (sd_lba),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .lba_err      (lba_err),
        .rd_blocks    (rd_blocks),
        .wr_blocks    (wr_blocks)
    );

    int checks = 0;
    int errors = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Initiator buffer: byte k holds ~k, two-cycle read latency.
    logic [7:0] din_p1, din_p2;
    always @(posedge CLK) begin
        din_p1 <= ~sd_buff_addr[7:0];
        din_p2 <= din_p1;
    end
    assign sd_buff_din = {4{din_p2}};

    // Memory: fetch byte = low address byte; stores checked against drive 2, lba 7.
    int stores = 0;
    int store_base = 0;
    int store_bad = 0;
    initial begin
        int k;
        mem_ack   = 1'b0;
        mem_rdata = 8'd0;
        forever begin
            @(negedge CLK);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_addr[7:0];
                if (mem_we) begin
                    k = stores - store_base;
                    if (mem_addr != {2'd2, 11'd7, k[8:0]} || mem_wdata != ~k[7:0]) store_bad++;
                    stores++;
                end
            end
        end
    end

    // Passive monitors.
    int rd_pulses = 0;
    int dout_bad = 0;
    int addr_bad = 0;
    int mreq_cycles = 0;
    int onehot_bad = 0;
    int stable_bad = 0;
    int acks = 0;
    bit zero_mode = 1'b0;
    logic [3:0] ack_log[$];
    initial begin
        logic [8:0]  nxt;
        logic        prev_req;
        logic [21:0] prev_addr;
        logic [3:0]  prev_ack;
        nxt = 9'd0;
        prev_req = 1'b0;
        prev_addr = '0;
        prev_ack = 4'd0;
        forever begin
            @(negedge CLK);
            if (sd_buff_wr) begin
                if (sd_buff_addr != nxt) addr_bad++;
                if (sd_buff_dout != (zero_mode ? 8'd0 : sd_buff_addr[7:0])) dout_bad++;
                nxt = sd_buff_addr + 9'd1;
                rd_pulses++;
            end
            if (mem_req) mreq_cycles++;
            if (mem_req && prev_req && mem_addr != prev_addr) stable_bad++;
            if ($countones(sd_ack) > 1) onehot_bad++;
            if (sd_ack != 4'd0 && prev_ack == 4'd0) begin
                ack_log.push_back(sd_ack);
                acks++;
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
            prev_ack  = sd_ack;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 20 && sd_ack == 4'd0; i++) @(negedge CLK);
        check(tag, 32'(sd_ack != 4'd0), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 8000 && sd_ack != 4'd0; i++) @(negedge CLK);
        check(tag, 32'(sd_ack), 32'd0);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int rp, mq, ab, sb, lb;
        RESET_N = 1'b0;
        sd_rd   = 4'd0;
        sd_wr   = 4'd0;
        sd_lba  = '0;
        repeat (2) @(negedge CLK);
        check("rst_ack", 32'(sd_ack), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_buff_wr", 32'(sd_buff_wr), 32'd0);
        check("rst_lba_err", 32'(lba_err), 32'd0);
        check("rst_rd_blocks", 32'(rd_blocks), 32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // All four drives request at once; each drops on its ack.
        lb = ack_log.size();
        sd_rd = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            wait_ack("rr_ack");
            sd_rd = sd_rd & ~sd_ack;
            wait_done("rr_done");
        end
        for (int n = 0; n < 4; n++) check("rr_order", 32'(ack_log[lb+n]), 32'(4'b0001 << n));
        check("rr_rd_blocks", 32'(rd_blocks), STATS ? 32'd4 : 32'd0);

        // Read drive 0, lba 3.
        rp = rd_pulses;
        dout_bad = 0;
        sd_lba[31:0] = 32'd3;
        sd_rd = 4'b0001;
        @(negedge CLK);
        check("rd0_ack_latency", 32'(sd_ack), 32'h1);
        @(negedge CLK);
        check("rd0_first_req", 32'(mem_req), 32'd1);
        check("rd0_first_addr", 32'(mem_addr), 32'({2'd0, 11'd3, 9'd0}));
        sd_rd = 4'b0000;
        wait_done("rd0_done");
        check("rd0_pulses", 32'(rd_pulses - rp), 32'd512);
        check("rd0_dout", 32'(dout_bad), 32'd0);
        check("rd0_last_addr", 32'(sd_buff_addr), 32'd511);
        check("rd0_rd_blocks", 32'(rd_blocks), STATS ? 32'd5 : 32'd0);

        // Write drive 2, lba 7.
        rp = rd_pulses;
        store_base = stores;
        sb = stores;
        sd_lba[95:64] = 32'd7;
        sd_wr = 4'b0100;
        wait_ack("wr2_ack");
        check("wr2_ack_val", 32'(sd_ack), 32'h4);
        sd_wr = 4'b0000;
        wait_done("wr2_done");
        check("wr2_stores", 32'(stores - sb), 32'd512);
        check("wr2_store_data", 32'(store_bad), 32'd0);
        check("wr2_no_buff_wr", 32'(rd_pulses - rp), 32'd0);
        check("wr2_wr_blocks", 32'(wr_blocks), STATS ? 32'd1 : 32'd0);
        check("wr2_lba_err", 32'(lba_err), 32'd0);

        // Out-of-range read, drive 1, lba 2048.
        rp = rd_pulses;
        mq = mreq_cycles;
        dout_bad = 0;
        zero_mode = 1'b1;
        sd_lba[63:32] = 32'd2048;
        sd_rd = 4'b0010;
        wait_ack("oor_ack");
        sd_rd = 4'b0000;
        wait_done("oor_done");
        zero_mode = 1'b0;
        check("oor_pulses", 32'(rd_pulses - rp), 32'd512);
        check("oor_zero_data", 32'(dout_bad), 32'd0);
        check("oor_no_mem_req", 32'(mreq_cycles - mq), 32'd0);
        check("oor_lba_err", 32'(lba_err), 32'd1);
        check("oor_rd_blocks", 32'(rd_blocks), STATS ? 32'd6 : 32'd0);

        // Request held after completion must not be re-served until dropped.
        sd_lba[31:0] = 32'd0;
        sd_rd = 4'b0001;
        wait_ack("hold_ack");
        wait_done("hold_done");
        ab = acks;
        repeat (20) @(negedge CLK);
        check("hold_no_reack", 32'(acks - ab), 32'd0);
        check("hold_ack_low", 32'(sd_ack), 32'd0);
        sd_rd = 4'b0000;
        @(negedge CLK);
        sd_rd = 4'b0001;
        wait_ack("rearm_ack");
        sd_rd = 4'b0000;
        wait_done("rearm_done");
        check("hold_rd_blocks", 32'(rd_blocks), STATS ? 32'd8 : 32'd0);
        check("lba_err_sticky", 32'(lba_err), 32'd1);

        // Reset in the middle of a write.
        do_reset();
        check("rst2_lba_err", 32'(lba_err), 32'd0);
        store_base = stores;
        sb = stores;
        sd_wr = 4'b0100;
        wait_ack("wr_abort_ack");
        sd_wr = 4'b0000;
        for (int i = 0; i < 2000 && (stores - sb) < 100; i++) @(negedge CLK);
        check("wr_abort_progress", 32'((stores - sb) >= 100), 32'd1);
        RESET_N = 1'b0;
        #1;
        check("abort_ack", 32'(sd_ack), 32'd0);
        check("abort_mem_req", 32'(mem_req), 32'd0);
        check("abort_wr_blocks", 32'(wr_blocks), 32'd0);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLK);
        check("abort_wr_blocks_after", 32'(wr_blocks), 32'd0);
        check("abort_idle", 32'(sd_ack), 32'd0);

        check("store_sequence", 32'(store_bad), 32'd0);
        check("buff_addr_order", 32'(addr_bad), 32'd0);
        check("mem_stable", 32'(stable_bad), 32'd0);
        check("ack_onehot", 32'(onehot_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
